// File: rtl/uut_name.sv
// Two-channel debouncer: out_1 = both filtered levels high, out_2 = change pulse.
// Define UUT_NAME_INPUT_SYNC_EN to add a 2-flop synchronizer ahead of each channel.
module uut_name #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    output logic out_1,
    output logic out_2,
    input  logic in_a,
    input  logic in_b
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       w_raw;
    logic [1:0]       w_s;
    logic [1:0]       r_filt;
    logic [1:0]       w_filt_nxt;
    logic [1:0]       w_chg;
    logic [CNT_W-1:0] r_cnt [2];
    logic             r_out_1;
    logic             r_out_2;

    assign w_raw = {in_b, in_a};

`ifdef UUT_NAME_INPUT_SYNC_EN
    logic [1:0] r_sync0;
    logic [1:0] r_sync1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= w_raw;
            r_sync1 <= r_sync0;
        end
    end

    assign w_s = r_sync1;
`else
    assign w_s = w_raw;
`endif

    // A level is accepted only on the edge its counter is already saturated.
    always_comb begin
        w_chg      = '0;
        w_filt_nxt = r_filt;
        for (int i = 0; i < 2; i++) begin
            w_chg[i] = (w_s[i] != r_filt[i]) && (r_cnt[i] == CNT_MAX);
            if (w_chg[i]) begin
                w_filt_nxt[i] = w_s[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_filt <= w_filt_nxt;
            for (int i = 0; i < 2; i++) begin
                if (w_s[i] == r_filt[i] || w_chg[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Outputs are registered copies so downstream logic sees clean levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_1 <= 1'b0;
            r_out_2 <= 1'b0;
        end else begin
            r_out_1 <= w_filt_nxt[0] & w_filt_nxt[1];
            r_out_2 <= |w_chg;
        end
    end

    assign out_1 = r_out_1;
    assign out_2 = r_out_2;

endmodule

// File: tb/tb_uut_name.sv
// Directed bench for uut_name with DB_CYCLES=4 and no input synchronizer.
module tb_uut_name;

    logic clk = 1'b0;
    logic rst;
    logic in_a;
    logic in_b;
    logic out_1;
    logic out_2;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic  rst;
        logic  a;
        logic  b;
        logic  o1;
        logic  o2;
        string nm;
    } vec_t;

    vec_t vecs[$];

    uut_name #(.DB_CYCLES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .out_1 (out_1),
        .out_2 (out_2),
        .in_a  (in_a),
        .in_b  (in_b)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic a, input logic b,
                       input logic o1, input logic o2, input string nm);
        vec_t v;
        v.rst = r;
        v.a   = a;
        v.b   = b;
        v.o1  = o1;
        v.o2  = o2;
        v.nm  = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic o1, input logic o2);
        n_chk++;
        if (out_1 === o1 && out_2 === o2) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got out_1=%b out_2=%b, want out_1=%b out_2=%b",
                     nm, out_1, out_2, o1, o2);
        end
    endtask

    task automatic step(input logic r, input logic a, input logic b);
        rst  = r;
        in_a = a;
        in_b = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        in_a = 1'b1;
        in_b = 1'b1;

        // reset with inputs high
        add(1, 1, 1, 0, 0, "rst0");
        add(1, 1, 1, 0, 0, "rst1");
        // both rise together: single pulse on 4th edge
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, "rise_wait");
        add(0, 1, 1, 1, 1, "rise_edge4");
        add(0, 1, 1, 1, 0, "rise_hold");
        // 3-cycle glitch on a is forgotten
        for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, "glitch_a");
        add(0, 1, 1, 1, 0, "glitch_end");
        add(0, 1, 1, 1, 0, "glitch_hold");
        // b falls after exactly 4 edges
        for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 0, "fall_b_wait");
        add(0, 1, 0, 0, 1, "fall_b_edge4");
        add(0, 1, 0, 0, 0, "fall_b_hold");
        // b back high
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, "rise_b_wait");
        add(0, 1, 1, 1, 1, "rise_b_edge4");
        add(0, 1, 1, 1, 0, "rise_b_hold");
        // alternate bounce on a for 20 cycles
        for (int i = 0; i < 20; i++) add(0, i[0], 1, 1, 0, "bounce_a");
        add(0, 1, 1, 1, 0, "bounce_end");
        // both fall together: one pulse
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, "fall_ab_wait");
        add(0, 0, 0, 0, 1, "fall_ab_edge4");
        add(0, 0, 0, 0, 0, "fall_ab_hold");
        // 00 -> 10
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, "a_only_wait");
        add(0, 1, 0, 0, 1, "a_only_edge4");
        // 10 -> 01 on one edge: pulse, out_1 stays low
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, "swap_wait");
        add(0, 0, 1, 0, 1, "swap_edge4");
        add(0, 0, 1, 0, 0, "swap_hold");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].b);
            check(vecs[i].nm, vecs[i].o1, vecs[i].o2);
        end

        // reset mid-debounce discards the partial count
        step(1, 0, 0);
        check("mid_rst_pre", 1'b0, 1'b0);
        step(0, 1, 0);
        check("mid_cnt1", 1'b0, 1'b0);
        step(0, 1, 0);
        check("mid_cnt2", 1'b0, 1'b0);
        step(1, 1, 0);
        check("mid_rst", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            check("mid_recount", 1'b0, 1'b0);
        end
        step(0, 1, 0);
        check("mid_edge4", 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1);
            check("mid_b_wait", 1'b0, 1'b0);
        end
        step(0, 1, 1);
        check("mid_b_edge4", 1'b1, 1'b1);
        step(0, 1, 1);
        check("mid_b_hold", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
